// File: rtl/rle_decoder.sv
// Run-length decoder: expands {count, symbol} tokens into count+1 copies of symbol on an AXI-Stream output.
// Define RLE_DECODER_STATS_EN to add SYM_COUNT / FRAME_COUNT handshake counters.
module rle_decoder #(
  parameter int SYM_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [CNT_W+SYM_W-1:0] S_AXIS_TDATA,
  input  logic                   S_AXIS_TVALID,
  output logic                   S_AXIS_TREADY,
  input  logic                   S_AXIS_TLAST,
  output logic [SYM_W-1:0]       M_AXIS_TDATA,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  output logic                   M_AXIS_TLAST
`ifdef RLE_DECODER_STATS_EN
  ,
  output logic [31:0]            SYM_COUNT,
  output logic [15:0]            FRAME_COUNT
`endif
);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [SYM_W-1:0] sym;
  } tok_t;

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t           state_q, state_d;
  tok_t             tok;
  logic [SYM_W-1:0] sym_q;
  logic [CNT_W-1:0] rem_q;
  logic             last_q;
  logic             rdy_q;
  logic             rem_zero;
  logic             load, dec;

  assign tok      = tok_t'(S_AXIS_TDATA);
  assign rem_zero = (rem_q == '0);

  // rdy_q keeps the input closed during reset and opens it on the first edge after release.
  always_comb begin
    state_d       = state_q;
    load          = 1'b0;
    dec           = 1'b0;
    S_AXIS_TREADY = 1'b0;
    case (state_q)
      IDLE: begin
        S_AXIS_TREADY = rdy_q;
        if (S_AXIS_TVALID && rdy_q) begin
          load    = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        // Final symbol of a run may hand off straight to the next token: no bubble.
        S_AXIS_TREADY = rdy_q && rem_zero && M_AXIS_TREADY;
        if (M_AXIS_TREADY) begin
          if (!rem_zero)          dec     = 1'b1;
          else if (S_AXIS_TVALID) load    = 1'b1;
          else                    state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      sym_q   <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      state_q <= state_d;
      if (load) begin
        sym_q  <= tok.sym;
        rem_q  <= tok.cnt;
        last_q <= S_AXIS_TLAST;
      end else if (dec) begin
        rem_q  <= rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign M_AXIS_TVALID = (state_q == EXPAND);
  assign M_AXIS_TDATA  = sym_q;
  assign M_AXIS_TLAST  = (state_q == EXPAND) && last_q && rem_zero;

`ifdef RLE_DECODER_STATS_EN
  logic m_hs;
  assign m_hs = M_AXIS_TVALID && M_AXIS_TREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      SYM_COUNT   <= '0;
      FRAME_COUNT <= '0;
    end else if (m_hs) begin
      SYM_COUNT <= SYM_COUNT + 32'd1;
      if (M_AXIS_TLAST) FRAME_COUNT <= FRAME_COUNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rle_decoder.sv
// Bench for rle_decoder: queue-based expansion model checked every cycle, plus literal per-scenario expectations.
module tb_rle_decoder;
  localparam int SYM_W = 8;
  localparam int CNT_W = 8;

  logic                   ACLK = 1'b0;
  logic                   ARESETN = 1'b0;
  logic [CNT_W+SYM_W-1:0] S_AXIS_TDATA = '0;
  logic                   S_AXIS_TVALID = 1'b0;
  logic                   S_AXIS_TREADY;
  logic                   S_AXIS_TLAST = 1'b0;
  logic [SYM_W-1:0]       M_AXIS_TDATA;
  logic                   M_AXIS_TVALID;
  logic                   M_AXIS_TREADY = 1'b1;
  logic                   M_AXIS_TLAST;
`ifdef RLE_DECODER_STATS_EN
  logic [31:0]            SYM_COUNT;
  logic [15:0]            FRAME_COUNT;
`endif

  rle_decoder #(.SYM_W(SYM_W), .CNT_W(CNT_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST)
`ifdef RLE_DECODER_STATS_EN
    , .SYM_COUNT(SYM_COUNT), .FRAME_COUNT(FRAME_COUNT)
`endif
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit armed;

  typedef struct {logic [7:0] sym; bit last;} exp_t;
  typedef struct {int cyc; logic [7:0] sym; logic last;} obs_t;
  exp_t q[$];
  obs_t log_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge ACLK) cyc <= cyc + 1;

  // Input side may only open once a clock edge has been seen out of reset.
  always @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) armed <= 1'b0;
    else          armed <= 1'b1;

  // Model: every accepted token becomes count+1 queued symbols; the queue front is what must be on the output.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      chk("rst_m_tvalid", M_AXIS_TVALID, 0);
      chk("rst_s_tready", S_AXIS_TREADY, 0);
      chk("rst_m_tlast", M_AXIS_TLAST, 0);
      chk("rst_m_tdata", M_AXIS_TDATA, 0);
      q.delete();
    end else begin
      chk("m_tvalid", M_AXIS_TVALID, q.size() != 0);
      chk("s_tready", S_AXIS_TREADY,
          armed && (q.size() == 0 || (q.size() == 1 && M_AXIS_TREADY)));
      if (q.size() != 0) begin
        chk("m_tdata", M_AXIS_TDATA, q[0].sym);
        chk("m_tlast", M_AXIS_TLAST, q[0].last);
        if (M_AXIS_TREADY) begin
          log_q.push_back('{cyc, M_AXIS_TDATA, M_AXIS_TLAST});
          void'(q.pop_front());
        end
      end
      if (S_AXIS_TVALID && S_AXIS_TREADY) begin
        for (int i = 0; i <= int'(S_AXIS_TDATA[15:8]); i++)
          q.push_back('{S_AXIS_TDATA[7:0], S_AXIS_TLAST && (i == int'(S_AXIS_TDATA[15:8]))});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the token was taken.
  task automatic send(input logic [7:0] c, input logic [7:0] s, input bit l);
    bit ok;
    ok = 1'b0;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = {c, s};
    S_AXIS_TLAST  = l;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge ACLK);
      ok = S_AXIS_TREADY;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge ACLK); #1;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA  = 16'($urandom);
    S_AXIS_TLAST  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge ACLK); #1;
      ok = (q.size() == 0) && !M_AXIS_TVALID;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic send_three();
    send(8'h00, 8'h11, 1'b0);
    send(8'h01, 8'h22, 1'b0);
    send(8'h00, 8'h33, 1'b1);
  endtask

  initial begin
    static bit [6:0] pat = 7'b1101001;  // bit i = TREADY in cycle i: 1,0,0,1,0,1,1
    static logic [7:0] t30_sym[4] = '{8'h11, 8'h22, 8'h22, 8'h33};
    int nbad;

    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;

    // Single run of 3 with TLAST on the final symbol
    log_q.delete();
    send(8'h02, 8'h41, 1'b1);
    wait_idle();
    chk("t29_len", log_q.size(), 3);
    if (log_q.size() == 3)
      for (int i = 0; i < 3; i++) begin
        chk("t29_sym", log_q[i].sym, 8'h41);
        chk("t29_last", log_q[i].last, i == 2);
        chk("t29_cyc", log_q[i].cyc - log_q[0].cyc, i);
      end

    // Back-to-back tokens, no bubble across boundaries
    log_q.delete();
    send_three();
    wait_idle();
    chk("t30_len", log_q.size(), 4);
    if (log_q.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t30_sym", log_q[i].sym, t30_sym[i]);
        chk("t30_last", log_q[i].last, i == 3);
        chk("t30_cyc", log_q[i].cyc - log_q[0].cyc, i);
      end

    // Maximum count: 256 symbols
    log_q.delete();
    send(8'hFF, 8'h5A, 1'b1);
    wait_idle();
    chk("t31_len", log_q.size(), 256);
    nbad = 0;
    foreach (log_q[i])
      if (log_q[i].sym !== 8'h5A || log_q[i].last !== (i == 255)) nbad++;
    chk("t31_bad_syms", nbad, 0);

    // Output stalls
    log_q.delete();
    send(8'h03, 8'h7E, 1'b1);
    for (int i = 0; i < 7; i++) begin
      M_AXIS_TREADY = pat[i];
      @(posedge ACLK); #1;
    end
    M_AXIS_TREADY = 1'b1;
    wait_idle();
    chk("t32_len", log_q.size(), 4);
    nbad = 0;
    foreach (log_q[i])
      if (log_q[i].sym !== 8'h7E || log_q[i].last !== (i == 3)) nbad++;
    chk("t32_bad_syms", nbad, 0);

    // Reset mid-run discards the held token
    log_q.delete();
    send(8'h04, 8'h99, 1'b1);
    for (int i = 0; i < 20 && log_q.size() < 2; i++) begin
      @(posedge ACLK); #1;
    end
    chk("t33_pre_len", log_q.size(), 2);
    ARESETN = 1'b0;
    #1;
    chk("t33_async_tvalid", M_AXIS_TVALID, 0);
    chk("t33_async_tready", S_AXIS_TREADY, 0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    log_q.delete();
    @(posedge ACLK); #1;
    send(8'h00, 8'h01, 1'b1);
    wait_idle();
    repeat (3) @(posedge ACLK);
    #1;
    chk("t33_len", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("t33_sym", log_q[0].sym, 8'h01);
      chk("t33_last", log_q[0].last, 1);
    end

    // Two frames after a fresh reset
    ARESETN = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    log_q.delete();
    send_three();
    send_three();
    wait_idle();
    chk("t34_len", log_q.size(), 8);
`ifdef RLE_DECODER_STATS_EN
    chk("t34_sym_count", SYM_COUNT, 8);
    chk("t34_frame_count", FRAME_COUNT, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rle_decoder.md
RLE_DECODER -- requirements
Module: rle_decoder

Interface
REQ-001 Parameter SYM_W, default 8: symbol width in bits.
REQ-002 Parameter CNT_W, default 8: run-count field width; field value n encodes run length n+1 (1..2^CNT_W).
REQ-003 ACLK  input  1  single clock; all state updates on its rising edge.
REQ-004 ARESETN  input  1  asynchronous, active-low reset.
REQ-005 S_AXIS_TDATA  input  CNT_W+SYM_W  encoded token {count[CNT_W-1:0], symbol[SYM_W-1:0]}, count in the MSBs.
REQ-006 S_AXIS_TVALID  input  1  token valid.
REQ-007 S_AXIS_TREADY  output  1  token accepted when TVALID and TREADY are both high on a rising edge.
REQ-008 S_AXIS_TLAST  input  1  token is the last of a frame.
REQ-009 M_AXIS_TDATA  output  SYM_W  decoded symbol.
REQ-010 M_AXIS_TVALID  output  1  decoded symbol valid.
REQ-011 M_AXIS_TREADY  input  1  downstream accepts a symbol when TVALID and TREADY are both high.
REQ-012 M_AXIS_TLAST  output  1  last symbol of the last run of a frame.

Function
REQ-013 The FSM SHALL have two states: IDLE (no token held) and EXPAND (token held, symbol on output).
- IDLE: S_AXIS_TREADY=1 and M_AXIS_TVALID=0.
- On token accept: latch symbol, remaining=count and last=TLAST; go to EXPAND.
REQ-014 In EXPAND, M_AXIS_TVALID SHALL be 1 and M_AXIS_TDATA SHALL equal the latched symbol. These outputs SHALL be driven from registers only.
REQ-015 In EXPAND, on each M_AXIS handshake with remaining>0, the block SHALL decrement remaining by 1.
REQ-016 M_AXIS_TLAST SHALL equal (last AND remaining==0).
REQ-017 S_AXIS_TREADY in EXPAND SHALL equal (remaining==0 AND M_AXIS_TREADY). It is combinational from M_AXIS_TREADY, which allows a back-to-back reload.
REQ-018 In EXPAND, when a handshake occurs with remaining==0:
- If a token is accepted in the same cycle, the block SHALL load it and stay in EXPAND.
- Otherwise it SHALL go to IDLE.
REQ-019 Throughput SHALL be one output symbol per cycle with continuous valid/ready, including across token boundaries (no bubble).
REQ-020 Latency from token accept to first M_AXIS_TVALID SHALL be 1 cycle.
REQ-021 While M_AXIS_TVALID=1 and M_AXIS_TREADY=0, M_AXIS_TDATA, M_AXIS_TLAST and remaining SHALL hold stable.
REQ-022 A token with count = 2^CNT_W-1 SHALL produce exactly 2^CNT_W symbols. remaining SHALL be CNT_W bits and never wrap below 0.
REQ-023 S_AXIS_TDATA and S_AXIS_TLAST SHALL be ignored when no handshake occurs.

Reset
REQ-024 ARESETN low SHALL immediately force state=IDLE, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, remaining=0 and last=0, independent of ACLK.
REQ-025 A reset during EXPAND SHALL discard the held token. No further symbols of that run SHALL be emitted after reset release.
REQ-026 S_AXIS_TREADY SHALL be 0 while ARESETN is low. It SHALL be 1 from the first rising edge after release.

Configuration
REQ-027 Macro RLE_DECODER_STATS_EN, when defined, SHALL add two ports:
- SYM_COUNT output 32: count of M_AXIS handshakes, wrapping at 2^32.
- FRAME_COUNT output 16: count of handshakes with M_AXIS_TLAST=1, wrapping at 2^16.
- Both SHALL be cleared by ARESETN.
REQ-028 Without RLE_DECODER_STATS_EN, those ports and counters SHALL not exist. Datapath behaviour SHALL be identical in both builds.

Verification
REQ-029 Token {0x02,0x41} TLAST=1, M_AXIS_TREADY=1 -> 0x41,0x41,0x41 on consecutive cycles; TLAST only on the third.
REQ-030 Tokens {0x00,0x11},{0x01,0x22},{0x00,0x33}, last with TLAST, continuous valid/ready -> 0x11,0x22,0x22,0x33 in 4 consecutive cycles, no bubble, TLAST on 0x33.
REQ-031 Token {0xFF,0x5A} TLAST=1 -> exactly 256 symbols of 0x5A, TLAST on the 256th, S_AXIS_TREADY=0 throughout the first 255.
REQ-032 Token {0x03,0x7E} with M_AXIS_TREADY toggling 1,0,0,1,0,1,1 -> exactly 4 outputs of 0x7E; data/TLAST stable during stalls.
REQ-033 ARESETN low for 1 cycle after 2 of 5 symbols of {0x04,0x99} -> M_AXIS_TVALID=0 immediately; no 0x99 afterwards; next token {0x00,0x01} -> single 0x01.
REQ-034 With RLE_DECODER_STATS_EN: REQ-030 stimulus sent twice -> SYM_COUNT=8 and FRAME_COUNT=2.
